// File: rtl/dcache_ctrl_pkg.sv
// Shared geometry and FSM encoding for the data-cache miss controller.
// Values describe the 2-way, 1 KB, 16 B-block Dcache_SRAM this controller drives.
package dcache_ctrl_pkg;

    localparam int DBLOCK_SIZE          = 16;
    localparam int DBLOCK_SIZE_BITS     = 4;
    localparam int DSET_INDEX_SIZE      = 5;
    localparam int DTAG_SIZE            = 23;
    localparam int DCACHE_ASSOCIATIVITY = 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_WB     = 3'd2;
    localparam logic [2:0] S_REFILL = 3'd3;
    localparam logic [2:0] S_FILL   = 3'd4;

endpackage

// File: rtl/dcache_lane_align.sv
// Combinational lane steering between a 32-bit CPU word and a 128-bit cache block.
// Zero latency; no flow control.
module dcache_lane_align (
    input  logic [127:0] block,
    input  logic [1:0]   word_sel,
    input  logic [3:0]   be,
    input  logic [31:0]  wdata,
    output logic [31:0]  word,
    output logic [15:0]  mask,
    output logic [127:0] wdata_rep
);

    assign word      = block[{word_sel, 5'b0} +: 32];
    assign mask      = {12'b0, be} << {word_sel, 2'b00};
    assign wdata_rep = {4{wdata}};

endmodule

// File: rtl/dcache_ctrl.sv
// Miss-handling controller for the 2-way data-cache SRAM: hit, dirty writeback, refill, replay.
// Hit acks 1 cycle after acceptance; cpu_ready low while busy; mem_req held until mem_ack.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = DBLOCK_SIZE_BITS,
    parameter int INDEX_W  = DSET_INDEX_SIZE,
    parameter int BLOCK_W  = 128,
    parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cpu_req,
    input  logic                       cpu_wen,
    input  logic [ADDR_W-1:0]          cpu_addr,
    input  logic [3:0]                 cpu_be,
    input  logic [31:0]                cpu_wdata,
    output logic                       cpu_ready,
    output logic                       cpu_ack,
    output logic [31:0]                cpu_rdata,
    output logic                       sram_en,
    output logic                       sram_wen,
    output logic                       sram_memWen,
    output logic [15:0]                sram_bytes,
    output logic [ADDR_W-OFFSET_W-1:0] sram_blockAddr,
    output logic [BLOCK_W-1:0]         sram_dataIn,
    input  logic                       sram_hit,
    input  logic                       sram_dirty,
    input  logic [BLOCK_W-1:0]         sram_dataOut,
    input  logic [TAG_W-1:0]           sram_victTag,
    input  logic [BLOCK_W-1:0]         sram_victData,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [BLOCK_W-1:0]         mem_wdata,
    input  logic                       mem_ack,
    input  logic [BLOCK_W-1:0]         mem_rdata
);

    logic [2:0]                 state, state_nxt;
    logic [ADDR_W-OFFSET_W-1:0] req_blk;
    logic [1:0]                 req_word;
    logic                       req_wen;
    logic [3:0]                 req_be;
    logic [31:0]                req_wdata;
    logic [TAG_W-1:0]           vict_tag;
    logic [BLOCK_W-1:0]         vict_data;
    logic [BLOCK_W-1:0]         fill_data;

    logic [31:0]                lane_word;
    logic [15:0]                lane_mask;
    logic [BLOCK_W-1:0]         lane_rep;

    dcache_lane_align u_lane (
        .block     (sram_dataOut),
        .word_sel  (req_word),
        .be        (req_be),
        .wdata     (req_wdata),
        .word      (lane_word),
        .mask      (lane_mask),
        .wdata_rep (lane_rep)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            req_blk   <= '0;
            req_word  <= '0;
            req_wen   <= 1'b0;
            req_be    <= '0;
            req_wdata <= '0;
            vict_tag  <= '0;
            vict_data <= '0;
            fill_data <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: if (cpu_req) begin
                    req_blk   <= cpu_addr[ADDR_W-1:OFFSET_W];
                    req_word  <= cpu_addr[3:2];
                    req_wen   <= cpu_wen;
                    req_be    <= cpu_be;
                    req_wdata <= cpu_wdata;
                end
                // Victim is captured on the miss so WB is independent of later SRAM outputs.
                S_LOOKUP: if (!sram_hit) begin
                    vict_tag  <= sram_victTag;
                    vict_data <= sram_victData;
                end
                S_REFILL: if (mem_ack) fill_data <= mem_rdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt      = state;
        cpu_ready      = 1'b0;
        cpu_ack        = 1'b0;
        cpu_rdata      = '0;
        sram_en        = 1'b0;
        sram_wen       = 1'b0;
        sram_memWen    = 1'b0;
        sram_bytes     = '0;
        sram_blockAddr = '0;
        sram_dataIn    = '0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        case (state)
            S_IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_req) state_nxt = S_LOOKUP;
            end
            S_LOOKUP: begin
                sram_en        = 1'b1;
                sram_blockAddr = req_blk;
                if (sram_hit) begin
                    cpu_ack   = 1'b1;
                    state_nxt = S_IDLE;
                    if (req_wen) begin
                        sram_wen    = 1'b1;
                        sram_bytes  = lane_mask;
                        sram_dataIn = lane_rep;
                    end else begin
                        cpu_rdata = lane_word;
                    end
                end else begin
                    state_nxt = sram_dirty ? S_WB : S_REFILL;
                end
            end
            S_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {vict_tag, req_blk[INDEX_W-1:0], {OFFSET_W{1'b0}}};
                mem_wdata = vict_data;
                if (mem_ack) state_nxt = S_REFILL;
            end
            S_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {req_blk, {OFFSET_W{1'b0}}};
                if (mem_ack) state_nxt = S_FILL;
            end
            S_FILL: begin
                sram_en        = 1'b1;
                sram_wen       = 1'b1;
                sram_memWen    = 1'b1;
                sram_blockAddr = req_blk;
                sram_dataIn    = fill_data;
                sram_bytes     = '1;
                state_nxt      = S_LOOKUP;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Miss-handling controller that sits directly upstream of the 2-way, 1 KB, 16 B-block data-cache SRAM (`Dcache_SRAM`).
- Accepts CPU load/store requests and drives that SRAM's enable, write, refill and byte-lane controls.
- On a miss it writes back the dirty victim, refills the block from memory, then replays the access.
- Sits between the MEM pipeline stage and the memory-side bus.

Parameters:
ADDR_W, 32, CPU byte address width
OFFSET_W, 4, block offset bits (16 B block)
INDEX_W, 5, set index bits (32 sets)
BLOCK_W, 128, block width in bits
TAG_W, ADDR_W-INDEX_W-OFFSET_W (23), tag width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
cpu_req  in  1  request valid
cpu_wen  in  1  1 = store, 0 = load
cpu_addr  in  32  byte address
cpu_be  in  4  byte enables within the addressed word
cpu_wdata  in  32  store data
cpu_ready  out  1  controller can accept a request
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  32  load data, valid while cpu_ack=1
sram_en  out  1  SRAM en
sram_wen  out  1  SRAM wen
sram_memWen  out  1  SRAM refill strobe
sram_bytes  out  16  SRAM byte-access mask
sram_blockAddr  out  28  {tag,index}
sram_dataIn  out  128  SRAM write data
sram_hit  in  1  SRAM hit
sram_dirty  in  1  selected victim is dirty
sram_dataOut  in  128  hit block data
sram_victTag  in  23  tag of selected victim way
sram_victData  in  128  data of selected victim way
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = block write, 0 = block read
mem_addr  out  32  block-aligned address, low 4 bits = 0
mem_wdata  out  128  writeback data
mem_ack  in  1  memory completion; mem_rdata valid this cycle
mem_rdata  in  128  refill data

Behaviour:
- States: IDLE, LOOKUP, WB, REFILL, FILL.
- Reset (rst=0, any state): state=IDLE, request/victim registers cleared, mem_req=0, cpu_ack=0, all sram_* = 0, cpu_ready=1. An outstanding memory transaction is abandoned; the bus must tolerate a dropped mem_req.
- IDLE: cpu_ready=1. On cpu_req at posedge, latch addr/wen/be/wdata and go to LOOKUP. cpu_ready=0 in all other states.
- LOOKUP:
  - sram_en=1, sram_blockAddr=latched addr[31:4].
  - Hit, load: cpu_ack=1, cpu_rdata=sram_dataOut[addr[3:2]*32 +: 32], then IDLE.
  - Hit, store: sram_wen=1, sram_bytes=be<<(4*addr[3:2]), sram_dataIn={4{wdata}}, cpu_ack=1, then IDLE.
  - Miss: latch sram_victTag/sram_victData. Go to WB if sram_dirty, else REFILL. sram_wen=0 on a miss.
- WB: mem_req=1, mem_we=1, mem_addr={victTag,index,4'b0}, mem_wdata=latched victim data. On mem_ack go to REFILL.
- REFILL: mem_req=1, mem_we=0, mem_addr={addr[31:4],4'b0}. On mem_ack latch mem_rdata and go to FILL.
- FILL: sram_en=1, sram_wen=1, sram_memWen=1, sram_dataIn=latched refill data, sram_bytes=16'hFFFF. Then LOOKUP (replay, which now hits).
- mem_req drops the cycle after mem_ack. mem_ack is ignored outside WB/REFILL. mem_ack may arrive at the earliest one cycle after mem_req rises.
- Latency: hit = ack 1 cycle after acceptance. Clean miss = 1 + refill wait + 1 (FILL) + 1 (LOOKUP). Dirty miss adds the writeback wait.
- cpu_req while cpu_ready=0 is ignored; the CPU must hold it.
- cpu_be=0 on a store: the access completes with no bytes modified.
- Back-to-back requests: the earliest next acceptance is the posedge after cpu_ack.

Decomposition:
- Shared package constants: DBLOCK_SIZE, DBLOCK_SIZE_BITS, DSET_INDEX_SIZE, DTAG_SIZE, DCACHE_ASSOCIATIVITY, and the state encoding.
- Natural sub-module: dcache_lane_align, which is purely combinational: word select from a 128-bit block, be-to-16-bit mask shift, and wdata replication.

Test Plan:
- Reset, then load 0x0000_0040 with the cache empty (clean miss) -> REFILL with mem_addr=0x40. mem_ack after 3 cycles with rdata word0=0xDEADBEEF -> FILL, LOOKUP hit, cpu_ack with cpu_rdata=0xDEADBEEF.
- Store be=4'b0011, wdata=0x1234_5678 to 0x44 (hit) -> cpu_ack 1 cycle after acceptance, sram_bytes=16'h0030; a subsequent load of 0x44 returns 0xXXXX5678 with the upper half unchanged.
- Fill both ways of set 2 with dirty blocks, then load a third tag in set 2 -> WB to the victim's address with the victim's data, then REFILL of the new block; cpu_ack only after FILL and LOOKUP.
- Assert rst=0 while in REFILL with mem_req=1 -> mem_req=0 immediately, state IDLE, cpu_ready=1 after reset is released.
- Hold cpu_req during a miss -> exactly one cpu_ack per accepted request, and no second acceptance before the ack.
- Pulse mem_ack while in IDLE -> no state change and no SRAM write.
